fetch_prefetch_unit: RTL and testbench
======================================

Name: fetch_prefetch_unit

Overview:
- Instruction-fetch front end. Sits directly upstream of the pipeline's IF/ID register and replaces the fixed-latency instruction memory read.
- Issues in-order PC+4 requests to a variable-latency instruction memory and buffers returned words with their PCs in a small FIFO.
- Presents {pc, instr} to the IF/ID register; honours the core's stall (load-use hazard) and redirect (taken branch/flush).

Parameters:
- PC_W, 9, program counter / fetch address width.
- INS_W, 32, instruction width.
- DEPTH, 4, prefetch FIFO entries (power of two, >=2).
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- mem_req  out  1  fetch request valid.
- mem_addr  out  PC_W  fetch address.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  response valid; responses return in request order.
- mem_rdata  in  INS_W  response instruction word.
- stall  in  1  consumer not ready; hold head entry.
- redirect  in  1  flush and refetch from redirect_pc.
- redirect_pc  in  PC_W  new fetch address.
- out_valid  out  1  head entry valid.
- out_pc  out  PC_W  PC of head entry.
- out_instr  out  INS_W  head instruction; 0 when out_valid=0.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high.
- Reset values: state=S_BOOT, fetch_pc=resp_pc=RESET_PC, FIFO empty, in_flight=0, discard=0. Outputs: out_valid=0, out_pc=0, out_instr=0, mem_req=0, mem_addr=RESET_PC.
- FSM states:
  - S_BOOT: one idle cycle after reset release, then S_RUN.
  - S_RUN: issue enabled.
  - S_DRAIN: issue blocked until all stale responses are discarded.
- Issue:
  - mem_req=1 iff state==S_RUN && !redirect && (count + in_flight) < DEPTH.
  - mem_addr=fetch_pc.
  - On mem_req&&mem_gnt: fetch_pc += 4, wrapping modulo 2^PC_W; in_flight += 1.
- Response: on mem_rvalid, in_flight -= 1.
  - If discard>0, drop the word and decrement discard.
  - Otherwise push {resp_pc, mem_rdata} and advance resp_pc += 4 (wraps).
  - Credit gating guarantees the FIFO never overflows. A push when full is an assertion error.
- Output:
  - out_valid = !empty; out_pc/out_instr driven combinationally from the head.
  - Pop when out_valid && !stall.
  - Latency: a response accepted in cycle N is visible at the output in cycle N+1.
  - Push and pop in the same cycle are both performed; count is unchanged.
- Redirect has priority over everything. In the redirect cycle:
  - No issue; FIFO cleared; any rvalid that cycle is dropped.
  - fetch_pc <= resp_pc <= redirect_pc.
  - discard <= in_flight − mem_rvalid.
  - Next state is S_DRAIN if that value >0, else S_RUN.
- S_DRAIN exits to S_RUN in the cycle discard goes 1→0.
- A redirect during S_DRAIN reloads discard by the same rule.
- Redirect during S_BOOT: load the PCs and go to S_RUN.
- Stall never blocks responses; it only blocks pop.
- An rvalid with in_flight==0 is an assertion error.
- Reset mid-operation returns all state to reset values immediately. Responses still in memory after reset release are the memory's responsibility; memory is reset on the same reset.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- With the macro:
  - Adds outputs perf_redirects[31:0] (count of redirect cycles), perf_empty_cycles[31:0] (cycles with out_valid=0 && state!=S_BOOT), perf_discards[31:0] (dropped responses).
  - All counters saturate at all-ones and reset to 0.
- Without the macro: these ports and counters are absent; core behaviour is identical.

Decomposition:
- Package fetch_pkg holds:
  - fetch_state_e {S_BOOT, S_RUN, S_DRAIN};
  - fetch_entry_t struct {pc[PC_W-1:0], instr[INS_W-1:0]};
  - localparam PC_STEP=4.
- One sub-module: fetch_fifo, a synchronous FIFO of fetch_entry_t.
  - Parameter DEPTH; ports: push, pop, flush, din, dout, empty, full, count.
  - Same clock and reset as the parent.

Test Plan:
- Zero-latency memory (gnt=1, rvalid the cycle after grant), stall=0, instr=addr<<2 → out_pc 0,4,8,… on consecutive cycles; out_instr matches; mem_req held high.
- stall=1 for 6 cycles with DEPTH=4:
  - FIFO fills to 4; mem_req drops when count+in_flight==4.
  - out_pc stays at the head.
  - Release → 4 entries drain in order with no gaps.
- 3-cycle memory latency, 3 requests outstanding, redirect to 0x40:
  - Next 3 responses discarded; state S_DRAIN, no issue.
  - First output is pc=0x040 with its correct word.
- Redirect coincident with rvalid and a full FIFO → word dropped; discard=in_flight−1; FIFO empty next cycle; out_instr=0.
- fetch_pc=0x1FC, PC_W=9 → next request address 0x000; resp_pc wraps identically.
- Assert reset while 2 requests are outstanding and FIFO count is 2:
  - Outputs return to reset values asynchronously.
  - After release: one S_BOOT cycle, then mem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch front end: FSM state, FIFO entry layout,
// fetch stride and a saturating counter helper used by the optional perf counters.
package fetch_pkg;

    localparam int FETCH_PC_W  = 9;
    localparam int FETCH_INS_W = 32;
    localparam int PC_STEP     = 4;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_DRAIN
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_PC_W-1:0]  pc;
        logic [FETCH_INS_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic en);
        return (en && (value != '1)) ? value + 32'd1 : value;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, instr} entries with a flush that empties it in one cycle.
// The head entry is presented combinationally on dout.
import fetch_pkg::*;

module fetch_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  fetch_entry_t               din,
    output fetch_entry_t               dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t    storage [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign dout    = storage[rd_ptr];

    // NOTE: storage is deliberately not reset; pointers and count alone decide which slots are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            storage[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Upstream credit gating must make an overflowing push impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && full && !pop));

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction prefetch front end: issues in-order PC+4 fetches to a variable-latency
// memory and buffers returned words for the IF/ID register. Optional FETCH_PERF_CNT_EN adds perf counters.
import fetch_pkg::*;

module fetch_prefetch_unit #(
    parameter int                  PC_W     = FETCH_PC_W,
    parameter int                  INS_W    = FETCH_INS_W,
    parameter int                  DEPTH    = 4,
    parameter logic [PC_W-1:0]     RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   mem_req,
    output logic [PC_W-1:0]        mem_addr,
    input  logic                   mem_gnt,
    input  logic                   mem_rvalid,
    input  logic [INS_W-1:0]       mem_rdata,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [PC_W-1:0]        redirect_pc,
    output logic                   out_valid,
    output logic [PC_W-1:0]        out_pc,
    output logic [INS_W-1:0]       out_instr
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]            perf_redirects,
    output logic [31:0]            perf_empty_cycles,
    output logic [31:0]            perf_discards
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e     state;
    logic [PC_W-1:0]  fetch_pc;
    logic [PC_W-1:0]  resp_pc;
    logic [CW-1:0]    in_flight;
    logic [CW-1:0]    discard;
    logic [CW-1:0]    fifo_count;
    logic [CW:0]      credit_used;
    logic [CW-1:0]    flight_after_rsp;
    logic             fifo_empty;
    logic             fifo_full;
    logic             issue;
    logic             push;
    logic             pop;
    logic             drop;
    fetch_entry_t     push_entry;
    fetch_entry_t     head_entry;

    // Each FIFO slot is reserved at issue time, so outstanding requests count against capacity.
    assign credit_used      = {1'b0, fifo_count} + {1'b0, in_flight};
    assign mem_req          = (state == S_RUN) && !redirect && (credit_used < (CW+1)'(DEPTH));
    assign mem_addr         = fetch_pc;
    assign issue            = mem_req && mem_gnt;
    assign flight_after_rsp = in_flight - CW'(mem_rvalid);

    assign push             = mem_rvalid && !redirect && (discard == '0);
    assign drop             = mem_rvalid && (redirect || (discard != '0));
    assign pop              = !fifo_empty && !stall && !redirect;
    assign push_entry.pc    = resp_pc;
    assign push_entry.instr = mem_rdata;

    assign out_valid        = !fifo_empty;
    assign out_pc           = out_valid ? head_entry.pc    : '0;
    assign out_instr        = out_valid ? head_entry.instr : '0;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .din   (push_entry),
        .dout  (head_entry),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    // NOTE: every register below uses non-blocking assignment so all updates see pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_BOOT;
            fetch_pc  <= RESET_PC;
            resp_pc   <= RESET_PC;
            in_flight <= '0;
            discard   <= '0;
        end else if (redirect) begin
            // Everything still in flight belongs to the old path and must be thrown away.
            fetch_pc  <= redirect_pc;
            resp_pc   <= redirect_pc;
            in_flight <= flight_after_rsp;
            discard   <= flight_after_rsp;
            state     <= (flight_after_rsp != '0) ? S_DRAIN : S_RUN;
        end else begin
            in_flight <= flight_after_rsp + CW'(issue);
            if (issue) begin
                fetch_pc <= fetch_pc + PC_W'(PC_STEP);
            end
            if (mem_rvalid) begin
                if (discard != '0) begin
                    discard <= discard - CW'(1);
                end else begin
                    resp_pc <= resp_pc + PC_W'(PC_STEP);
                end
            end
            case (state)
                S_BOOT:  state <= S_RUN;
                S_DRAIN: begin
                    if ((discard == '0) || (mem_rvalid && (discard == CW'(1)))) begin
                        state <= S_RUN;
                    end
                end
                default: state <= state;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_redirects    <= '0;
            perf_empty_cycles <= '0;
            perf_discards     <= '0;
        end else begin
            perf_redirects    <= sat_inc(perf_redirects, redirect);
            perf_empty_cycles <= sat_inc(perf_empty_cycles, !out_valid && (state != S_BOOT));
            perf_discards     <= sat_inc(perf_discards, drop);
        end
    end
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

    a_rvalid_has_request: assert property (@(posedge clk) disable iff (reset)
        mem_rvalid |-> (in_flight != '0));

    a_fifo_full_no_credit: assert property (@(posedge clk) disable iff (reset)
        fifo_full |-> !mem_req);

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit: behavioural memory with configurable latency
// and an epoch-tagged scoreboard of expected {pc, instr} outputs.
module tb_fetch_prefetch_unit;

    localparam int PC_W  = 9;
    localparam int INS_W = 32;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              mem_req;
    logic [PC_W-1:0]   mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [INS_W-1:0]  mem_rdata;
    logic              stall;
    logic              redirect;
    logic [PC_W-1:0]   redirect_pc;
    logic              out_valid;
    logic [PC_W-1:0]   out_pc;
    logic [INS_W-1:0]  out_instr;

    fetch_prefetch_unit #(
        .PC_W     (PC_W),
        .INS_W    (INS_W),
        .DEPTH    (DEPTH),
        .RESET_PC (9'h000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_pc      (out_pc),
        .out_instr   (out_instr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PC_W-1:0]  addr;
        logic [INS_W-1:0] data;
        int               ready;
        int               ep;
    } pend_t;

    typedef struct {
        logic [PC_W-1:0]  pc;
        logic [INS_W-1:0] instr;
    } exp_t;

    pend_t            pend[$];
    exp_t             sb[$];
    int               checks = 0;
    int               errors = 0;
    int               cyc = 0;
    int               lat = 1;
    int               epoch = 0;
    int               rv_ep = 0;
    int               wrap_pops = 0;
    bit               check_req = 1'b0;
    bit               want_first_en = 1'b0;
    logic [PC_W-1:0]  want_first_pc;
    logic [PC_W-1:0]  rv_addr;
    logic [PC_W-1:0]  exp_addr = 9'h000;
    logic [PC_W-1:0]  prev_pop_pc = 9'h000;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [INS_W-1:0] mk_data(input logic [PC_W-1:0] a, input int ep);
        logic [31:0] e;
        e = ep;
        return {e[7:0], 13'h0, a, 2'b00};
    endfunction

    // One clock cycle: check outputs against the model, account for issue/response, advance.
    task automatic tick();
        int   pre_count;
        int   outstanding;
        int   stale;
        exp_t e;
        pend_t p;
        #1;
        pre_count = sb.size();
        check("out_valid", 64'(out_valid), 64'(pre_count > 0));
        if (!out_valid) begin
            check("out_pc_idle", 64'(out_pc), 64'(0));
            check("out_instr_idle", 64'(out_instr), 64'(0));
        end
        if (stall && out_valid && pre_count > 0) begin
            check("head_hold_pc", 64'(out_pc), 64'(sb[0].pc));
        end
        if (out_valid && !stall && !redirect && pre_count > 0) begin
            e = sb.pop_front();
            check("out_pc", 64'(out_pc), 64'(e.pc));
            check("out_instr", 64'(out_instr), 64'(e.instr));
            if (want_first_en) begin
                check("first_after_redirect", 64'(out_pc), 64'(want_first_pc));
                want_first_en = 1'b0;
            end
            if (e.pc == 9'h000 && prev_pop_pc == 9'h1FC) wrap_pops++;
            prev_pop_pc = e.pc;
        end
        outstanding = pend.size() + int'(mem_rvalid);
        stale = 0;
        foreach (pend[i]) if (pend[i].ep != epoch) stale++;
        if (mem_rvalid && rv_ep != epoch) stale++;
        if (stale > 0) begin
            check("no_issue_while_draining", 64'(mem_req), 64'(0));
        end else if (check_req) begin
            check("mem_req_credit", 64'(mem_req), 64'(!redirect && (pre_count + outstanding < DEPTH)));
        end
        if (mem_req && mem_gnt) begin
            check("mem_addr", 64'(mem_addr), 64'(exp_addr));
            pend.push_back('{addr: exp_addr, data: mk_data(exp_addr, epoch), ready: cyc + lat, ep: epoch});
            exp_addr = exp_addr + 9'd4;
        end
        if (redirect) begin
            sb.delete();
            epoch++;
            exp_addr = redirect_pc;
        end else if (mem_rvalid && rv_ep == epoch) begin
            sb.push_back('{pc: rv_addr, instr: mem_rdata});
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (pend.size() > 0 && pend[0].ready <= cyc) begin
            p          = pend.pop_front();
            mem_rvalid = 1'b1;
            mem_rdata  = p.data;
            rv_addr    = p.addr;
            rv_ep      = p.ep;
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = 32'hDEAD_BEEF;
        end
    endtask

    task automatic do_redirect(input logic [PC_W-1:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        tick();
        redirect    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;
        reset       = 1'b1;
        mem_gnt     = 1'b1;
        mem_rvalid  = 1'b0;
        mem_rdata   = 32'hDEAD_BEEF;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 9'h000;
        rv_addr     = 9'h000;

        // Reset values and the single boot cycle.
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_pc", 64'(out_pc), 64'(0));
        check("rst_out_instr", 64'(out_instr), 64'(0));
        check("rst_mem_req", 64'(mem_req), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(9'h000));
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("boot_no_req", 64'(mem_req), 64'(0));
        tick();
        #1;
        check("run_req", 64'(mem_req), 64'(1));
        check("run_addr", 64'(mem_addr), 64'(9'h000));

        // Zero-latency streaming.
        check_req = 1'b1;
        lat = 1;
        repeat (12) tick();

        // Stall: FIFO fills, issue stops on credit, head held; then drain in order.
        stall = 1'b1;
        repeat (6) tick();
        stall = 1'b0;
        repeat (8) tick();

        // Three-cycle latency, redirect with three requests outstanding.
        lat = 3;
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            if (pend.size() + int'(mem_rvalid) == 3) found = 1'b1;
            else tick();
        end
        check("wait_three_outstanding", 64'(found), 64'(1));
        want_first_pc = 9'h040;
        want_first_en = 1'b1;
        do_redirect(9'h040);
        repeat (20) tick();
        check("first_after_redirect_seen", 64'(want_first_en), 64'(0));

        // Redirect coincident with a response while the FIFO is one short of full.
        lat = 2;
        do_redirect(9'h080);
        stall = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 30 && !found; n++) begin
            if (mem_rvalid && sb.size() == 3) found = 1'b1;
            else tick();
        end
        check("wait_full_with_rvalid", 64'(found), 64'(1));
        stall = 1'b0;
        do_redirect(9'h100);
        #1;
        check("flush_out_valid", 64'(out_valid), 64'(0));
        check("flush_out_instr", 64'(out_instr), 64'(0));
        repeat (10) tick();

        // Address wrap modulo 2^PC_W.
        lat = 1;
        do_redirect(9'h1F8);
        repeat (10) tick();
        check("pc_wrap_seen", 64'(wrap_pops > 0), 64'(1));

        // Asynchronous reset with two outstanding requests and two buffered entries.
        lat = 3;
        stall = 1'b1;
        do_redirect(9'h020);
        found = 1'b0;
        for (int n = 0; n < 30 && !found; n++) begin
            if (sb.size() == 2 && pend.size() + int'(mem_rvalid) >= 2) found = 1'b1;
            else tick();
        end
        check("wait_mid_op", 64'(found), 64'(1));
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_out_valid", 64'(out_valid), 64'(0));
        check("async_rst_out_pc", 64'(out_pc), 64'(0));
        check("async_rst_out_instr", 64'(out_instr), 64'(0));
        check("async_rst_mem_req", 64'(mem_req), 64'(0));
        check("async_rst_mem_addr", 64'(mem_addr), 64'(9'h000));
        pend.delete();
        sb.delete();
        epoch++;
        exp_addr   = 9'h000;
        mem_rvalid = 1'b0;
        stall      = 1'b0;
        check_req  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reboot_no_req", 64'(mem_req), 64'(0));
        tick();
        #1;
        check("reboot_req", 64'(mem_req), 64'(1));
        check("reboot_addr", 64'(mem_addr), 64'(9'h000));
        check_req = 1'b1;
        lat = 1;
        repeat (10) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
